// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: hazard-unit state encoding, the hardwired zero
// register and the default memory-wait limits.
package cpu_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MEM_TIMEOUT_DEF = 16;
  localparam int         CNT_W_DEF       = 8;

endpackage

// File: rtl/hazard_unit_mem_wait_timer.sv
// Counts cycles spent waiting on data memory and flags the abort point.
// start loads 1, clear returns to idle (0), a non-zero count keeps advancing.
module mem_wait_timer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  input  logic clear,
  output logic timeout
);

  logic [CNT_W-1:0] waitCnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order in which blocks are evaluated.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      waitCnt <= '0;
    end else if (clear) begin
      waitCnt <= '0;
    end else if (start) begin
      waitCnt <= CNT_W'(1);
    end else if (waitCnt != '0) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // An idle counter reads 0, which never matches since MEM_TIMEOUT >= 2.
  assign timeout = (waitCnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/hazard_unit.sv
// ID-side stall/flush controller: load-use bubble, taken-branch flush and
// memory-wait freeze with timeout. HAZARD_PERF_EN adds stall/flush counters.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RegRS_i,
  input  logic [4:0]       ID_RegRT_i,
  input  logic             IE_MemRead_i,
  input  logic [4:0]       IE_RegRT_i,
  input  logic             ID_BranchTaken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Freeze_o,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic             err_o
);

  state_t state;
  logic   timeout;
  logic   timerStart;
  logic   timerClear;
  logic   freezeC;
  logic   loadUseC;

  assign timerStart = (state == ST_RUN) && mem_req_i && !mem_ack_i;
  assign timerClear = (state == ST_MEM_WAIT) && (mem_ack_i || timeout);

  assign freezeC  = ((state == ST_RUN) && mem_req_i && !mem_ack_i) ||
                    ((state == ST_MEM_WAIT) && !mem_ack_i && !timeout);
  assign loadUseC = IE_MemRead_i && (IE_RegRT_i != REG_ZERO) &&
                    ((IE_RegRT_i == ID_RegRS_i) || (IE_RegRT_i == ID_RegRT_i));

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (timerStart),
    .clear  (timerClear),
    .timeout(timeout)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_RUN;
      err_o <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (timerStart) state <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          // Ack outranks a coinciding timeout, so err_o is set only on a true abort.
          if (mem_ack_i) begin
            state <= ST_RUN;
          end else if (timeout) begin
            state <= ST_RUN;
            err_o <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // NOTE: every output gets a default before the priority chain, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    Freeze_o      = 1'b0;
    if (rst_i) begin
      if (freezeC) begin
        Freeze_o     = 1'b1;
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
      end else if (loadUseC) begin
        PCWrite_o     = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Bubble_o = 1'b1;
      end else if (ID_BranchTaken_i) begin
        IFID_Flush_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((Freeze_o || IDEX_Bubble_o) && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (IFID_Flush_o && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: each step pushes the expected control word
// and pops it at the following falling edge to compare with the DUT outputs.
module tb_hazard_unit;

`ifdef HAZARD_PERF_EN
  localparam int MT = 4;
  localparam int CW = 2;
`else
  localparam int MT = 16;
  localparam int CW = 8;
`endif

  // Control word layout: {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Freeze, err}
  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] BUB   = 6'b000100;
  localparam logic [5:0] FLUSH = 6'b111000;
  localparam logic [5:0] FRZ   = 6'b000010;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [4:0]    ID_RegRS_i, ID_RegRT_i, IE_RegRT_i;
  logic          IE_MemRead_i, ID_BranchTaken_i, mem_req_i, mem_ack_i;
  logic          PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o, err_o;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
`endif

  int            nChecks = 0;
  int            nFails  = 0;
  logic [5:0]    sb[$];

  always #5 clk_i = ~clk_i;

  hazard_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ID_RegRS_i      (ID_RegRS_i),
    .ID_RegRT_i      (ID_RegRT_i),
    .IE_MemRead_i    (IE_MemRead_i),
    .IE_RegRT_i      (IE_RegRT_i),
    .ID_BranchTaken_i(ID_BranchTaken_i),
    .mem_req_i       (mem_req_i),
    .mem_ack_i       (mem_ack_i),
    .PCWrite_o       (PCWrite_o),
    .IFID_Write_o    (IFID_Write_o),
    .IFID_Flush_o    (IFID_Flush_o),
    .IDEX_Bubble_o   (IDEX_Bubble_o),
    .Freeze_o        (Freeze_o),
`ifdef HAZARD_PERF_EN
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
`endif
    .err_o           (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (just after a rising edge), record the expected
  // control word, then compare at the falling edge.
  task automatic step(input string tag, input logic rst, input logic [4:0] rs,
                      input logic [4:0] rt, input logic memRead, input logic [4:0] ieRt,
                      input logic br, input logic req, input logic ack,
                      input logic [5:0] exp);
    logic [5:0] got;
    rst_i            = rst;
    ID_RegRS_i       = rs;
    ID_RegRT_i       = rt;
    IE_MemRead_i     = memRead;
    IE_RegRT_i       = ieRt;
    ID_BranchTaken_i = br;
    mem_req_i        = req;
    mem_ack_i        = ack;
    sb.push_back(exp);
    @(negedge clk_i);
    got = {PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o, err_o};
    check(tag, 32'(got), 32'(sb.pop_front()));
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input string tag, input logic [5:0] exp);
    step(tag, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    // Reset forces default controls even with every hazard asserted.
    step("rst_hold0", 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, NORM);
    step("rst_hold1", 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, NORM);
    idle("post_rst", NORM);

    // Load-use on rs, on rt, and the $zero exception.
    step("lu_rs",   1'b1, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, BUB);
    step("lu_done", 1'b1, 5'd8, 5'd3, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, NORM);
    step("lu_zero", 1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
    step("lu_rt",   1'b1, 5'd4, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, BUB);
    step("lu_miss", 1'b1, 5'd4, 5'd9, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, NORM);

    // Load-use outranks the branch flush; flush follows once the bubble is in.
    step("lu_br",    1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, BUB);
    step("br_flush", 1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, FLUSH);
    idle("br_done", NORM);

    // Three-cycle memory wait, released in the ack cycle.
    step("mw_run",  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("mw_w1",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("mw_w2",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("mw_ack",  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);
    idle("mw_back_run", NORM);

    // Zero-latency access never freezes and stays in RUN.
    step("zl_ack", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);
    idle("zl_run", NORM);

    // Freeze outranks load-use and flush; exactly one bubble after release.
    step("fz_lu_br",  1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, FRZ);
    step("fz_lu_w1",  1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, FRZ);
    step("fz_rel_lu", 1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, BUB);
    step("fz_flush",  1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, FLUSH);
    idle("fz_done", NORM);

    // Ack arriving exactly on the timeout cycle wins; no error.
    for (int i = 0; i < MT - 1; i++)
      step($sformatf("ackto_frz%0d", i), 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("ackto_rel", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);
    idle("ackto_noerr", NORM);

    // Timeout without ack: MT-1 frozen cycles, release, then sticky err.
    for (int i = 0; i < MT - 1; i++)
      step($sformatf("to_frz%0d", i), 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("to_rel", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, NORM);
    idle("to_err", NORM | 6'b000001);
    step("to_sticky", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM | 6'b000001);

    // Reset in the second MEM_WAIT cycle aborts silently and clears err.
    step("rw_run", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ | 6'b000001);
    step("rw_w1",  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ | 6'b000001);
    step("rw_rst", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, NORM | 6'b000001);
    idle("rw_after", NORM);
    // A fresh wait must run the full MT-1 freeze, proving the counter restarted.
    for (int i = 0; i < MT - 1; i++)
      step($sformatf("rw_frz%0d", i), 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("rw_ack", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);

`ifdef HAZARD_PERF_EN
    // Two bubbles, three freeze cycles, one flush; stall count saturates at 3.
    step("pf_rst", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
    step("pf_b1",  1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, BUB);
    step("pf_b2",  1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, BUB);
    step("pf_f1",  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("pf_f2",  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("pf_f3",  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
    step("pf_ack", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);
    step("pf_fl",  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, FLUSH);
    idle("pf_idle", NORM);
    check("stall_cnt_sat", 32'(stall_cnt_o), 32'd3);
    check("flush_cnt",     32'(flush_cnt_o), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
